bram_fifo_ctrl: RTL and testbench

- Synchronous stream FIFO: a valid/ready write port in, a first-word-fall-through valid/ready read port out.
- Storage is a simple dual-port block RAM with registered read and read enable. This block sequences that RAM's write port A and read port B.
- A small register prefetch buffer hides the RAM read latency, so the block sustains one word per cycle.
- Used as the standard deep buffer between streaming stages in the lab designs.

---
 rtl/bram_fifo_pkg.sv | 19 +
 rtl/bram_fifo_mem.sv | 28 ++
 rtl/bram_fifo_ctrl.sv | 108 ++++++++++
 tb/tb_bram_fifo_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_fifo_pkg.sv
// Shared constants and helpers for the block-RAM stream FIFO.
// Covers the prefetch buffer sizing, count width and prefetch index type.
package bram_fifo_pkg;

    // Prefetch depth covers the issue -> RAM register -> capture credit loop.
    localparam int PF_DEPTH = 3;

    typedef logic [1:0] pf_idx_t;

    // Occupancy spans RAM words plus up to PF_DEPTH words outside the RAM.
    function automatic int count_width(input int addr_bits);
        return addr_bits + 2;
    endfunction

    function automatic pf_idx_t pf_next(input pf_idx_t idx);
        return (idx == pf_idx_t'(PF_DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/bram_fifo_mem.sv
// Simple dual-port storage: write port A, enabled read port B with registered data.
// Written so that synthesis maps it onto a block RAM.
module bram_fifo_mem #(
    parameter int DATA_W    = 8,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk_i,
    input  logic                 we_a,
    input  logic [ADDR_BITS-1:0] addr_a,
    input  logic [DATA_W-1:0]    din_a,
    input  logic                 en_b,
    input  logic [ADDR_BITS-1:0] addr_b,
    output logic [DATA_W-1:0]    dout_b
);

    logic [DATA_W-1:0] mem [2**ADDR_BITS];

    // NOTE: no reset on the array or the read register; a reset would stop block-RAM inference.
    always_ff @(posedge clk_i) begin
        if (we_a) begin
            mem[addr_a] <= din_a;
        end
        if (en_b) begin
            dout_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Stream FIFO controller: sequences the RAM ports and hides read latency
// behind a small register prefetch buffer for first-word-fall-through output.
module bram_fifo_ctrl
    import bram_fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_BITS = 10
) (
    input  logic                                 clk_i,
    input  logic                                 rstn_i,
    input  logic                                 s_valid_i,
    input  logic [DATA_W-1:0]                    s_data_i,
    output logic                                 s_ready_o,
    output logic                                 m_valid_o,
    output logic [DATA_W-1:0]                    m_data_o,
    input  logic                                 m_ready_i,
    output logic [count_width(ADDR_BITS)-1:0]    count_o,
    output logic                                 full_o,
    output logic                                 empty_o
);

    localparam int CNT_W = count_width(ADDR_BITS);
    localparam logic [ADDR_BITS:0] MEM_FULL = {1'b1, {ADDR_BITS{1'b0}}};

    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS:0]   mem_cnt;
    logic                 inflight;
    logic [1:0]           pf_cnt;
    pf_idx_t              pf_head;
    pf_idx_t              pf_tail;
    logic [DATA_W-1:0]    pf_buf [PF_DEPTH];
    logic [DATA_W-1:0]    ram_dout;
    logic [2:0]           pf_committed;
    logic                 push;
    logic                 pop;
    logic                 issue;

    bram_fifo_mem #(
        .DATA_W    (DATA_W),
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk_i  (clk_i),
        .we_a   (push),
        .addr_a (wr_ptr),
        .din_a  (s_data_i),
        .en_b   (issue),
        .addr_b (rd_ptr),
        .dout_b (ram_dout)
    );

    // Prefetch slots already claimed: held words plus the read on its way back.
    assign pf_committed = {1'b0, pf_cnt} + {2'b00, inflight};

    assign s_ready_o = (mem_cnt < MEM_FULL);
    assign full_o    = !s_ready_o;
    assign push      = s_valid_i && s_ready_o;
    assign m_valid_o = (pf_cnt != 2'd0);
    assign m_data_o  = pf_buf[pf_head];
    assign pop       = m_valid_o && m_ready_i;
    assign issue     = (mem_cnt != '0) && (pf_committed < 3'(PF_DEPTH));
    assign count_o   = CNT_W'(mem_cnt) + CNT_W'(pf_committed);
    assign empty_o   = (count_o == '0);

    // NOTE: all state below uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
            pf_cnt   <= 2'd0;
            pf_head  <= '0;
            pf_tail  <= '0;
            for (int i = 0; i < PF_DEPTH; i++) begin
                pf_buf[i] <= '0;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !issue) begin
                mem_cnt <= mem_cnt + 1'b1;
            end else if (!push && issue) begin
                mem_cnt <= mem_cnt - 1'b1;
            end

            // Clearing inflight on reset drops a read result landing just after it.
            inflight <= issue;
            if (inflight) begin
                pf_buf[pf_tail] <= ram_dout;
                pf_tail         <= pf_next(pf_tail);
            end
            if (pop) begin
                pf_head <= pf_next(pf_head);
            end
            if (inflight && !pop) begin
                pf_cnt <= pf_cnt + 1'b1;
            end else if (!inflight && pop) begin
                pf_cnt <= pf_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench for bram_fifo_ctrl with a 16-word RAM.
// A queue scoreboard tracks accepted words and occupancy against the DUT outputs.
module tb_bram_fifo_ctrl;

    localparam int DATA_W    = 8;
    localparam int ADDR_BITS = 4;
    localparam int CNT_W     = ADDR_BITS + 2;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic              s_valid_i;
    logic [DATA_W-1:0] s_data_i;
    logic              s_ready_o;
    logic              m_valid_o;
    logic [DATA_W-1:0] m_data_o;
    logic              m_ready_i;
    logic [CNT_W-1:0]  count_o;
    logic              full_o;
    logic              empty_o;

    int total = 0;
    int bad   = 0;
    int model_cnt = 0;
    int n_push = 0;
    logic [DATA_W-1:0] sb_q[$];

    bram_fifo_ctrl #(
        .DATA_W    (DATA_W),
        .ADDR_BITS (ADDR_BITS)
    ) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .s_valid_i (s_valid_i),
        .s_data_i  (s_data_i),
        .s_ready_o (s_ready_o),
        .m_valid_o (m_valid_o),
        .m_data_o  (m_data_o),
        .m_ready_i (m_ready_i),
        .count_o   (count_o),
        .full_o    (full_o),
        .empty_o   (empty_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a falling edge with inputs set; scores this cycle, then advances one cycle.
    task automatic cycle();
        bit push;
        bit pop;
        logic [DATA_W-1:0] exp;
        push = s_valid_i && s_ready_o;
        pop  = m_valid_o && m_ready_i;
        total++;
        if (full_o !== !s_ready_o)
            begin bad++; $display("FAIL full_vs_ready: full=%b ready=%b", full_o, s_ready_o); end
        total++;
        if (dut.inflight && dut.pf_cnt == 2'd3 && !pop)
            begin bad++; $display("FAIL pf_overflow: capture into full prefetch buffer"); end
        if (pop) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++; $display("FAIL spurious_out: got %0h expected no word", m_data_o);
            end else begin
                exp = sb_q.pop_front();
                if (m_data_o !== exp)
                    begin bad++; $display("FAIL order: got %0h expected %0h", m_data_o, exp); end
            end
            model_cnt--;
        end
        if (push) begin
            sb_q.push_back(s_data_i);
            model_cnt++;
            n_push++;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        total++;
        if (count_o !== CNT_W'(model_cnt))
            begin bad++; $display("FAIL count: got %0d expected %0d", count_o, model_cnt); end
        total++;
        if (empty_o !== (model_cnt == 0))
            begin bad++; $display("FAIL empty: got %b expected %b", empty_o, model_cnt == 0); end
    endtask

    task automatic do_reset();
        rstn_i    = 1'b0;
        s_valid_i = 1'b0;
        m_ready_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        sb_q.delete();
        model_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total += 6;
        if (s_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b expected 1", s_ready_o); end
        if (m_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b expected 0", m_valid_o); end
        if (count_o !== '0)     begin bad++; $display("FAIL rst_count: got %0d expected 0", count_o); end
        if (full_o !== 1'b0)    begin bad++; $display("FAIL rst_full: got %b expected 0", full_o); end
        if (empty_o !== 1'b1)   begin bad++; $display("FAIL rst_empty: got %b expected 1", empty_o); end
        if (m_data_o !== '0)    begin bad++; $display("FAIL rst_data: got %0h expected 0", m_data_o); end
    endtask

    // Push one word in cycle 0 and expect it at the head exactly in cycle 3.
    task automatic check_latency(input logic [DATA_W-1:0] word, input string tag);
        s_valid_i = 1'b1;
        s_data_i  = word;
        m_ready_i = 1'b1;
        cycle();
        s_valid_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            total++;
            if (m_valid_o !== 1'(k == 3))
                begin bad++; $display("FAIL %s_valid_c%0d: got %b expected %b", tag, k, m_valid_o, k == 3); end
            if (k == 3) begin
                total++;
                if (m_data_o !== word)
                    begin bad++; $display("FAIL %s_data: got %0h expected %0h", tag, m_data_o, word); end
            end
            if (k == 4) begin
                total++;
                if (empty_o !== 1'b1)
                    begin bad++; $display("FAIL %s_empty: got %b expected 1", tag, empty_o); end
            end
            cycle();
        end
    endtask

    task automatic test_latency();
        check_latency(8'hA5, "latency");
    endtask

    task automatic test_stall_burst();
        m_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = DATA_W'(i);
            cycle();
        end
        s_valid_i = 1'b0;
        repeat (3) cycle();
        total += 3;
        if (count_o !== CNT_W'(10)) begin bad++; $display("FAIL stall_count: got %0d expected 10", count_o); end
        if (m_valid_o !== 1'b1)     begin bad++; $display("FAIL stall_valid: got %b expected 1", m_valid_o); end
        if (m_data_o !== 8'h00)     begin bad++; $display("FAIL stall_head: got %0h expected 0", m_data_o); end
        m_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (m_valid_o !== 1'b1)
                begin bad++; $display("FAIL burst_bubble_%0d: got %b expected 1", i, m_valid_o); end
            cycle();
        end
        total++;
        if (empty_o !== 1'b1) begin bad++; $display("FAIL burst_empty: got %b expected 1", empty_o); end
    endtask

    task automatic test_full();
        int start;
        start = n_push;
        m_ready_i = 1'b0;
        for (int c = 0; c < 40 && s_ready_o; c++) begin
            s_valid_i = 1'b1;
            s_data_i  = DATA_W'(8'h40 + c);
            cycle();
        end
        total += 3;
        if (n_push - start != 19) begin bad++; $display("FAIL full_accepted: got %0d expected 19", n_push - start); end
        if (full_o !== 1'b1)      begin bad++; $display("FAIL full_flag: got %b expected 1", full_o); end
        if (count_o !== CNT_W'(19)) begin bad++; $display("FAIL full_count: got %0d expected 19", count_o); end
        for (int c = 0; c < 5; c++) begin
            s_valid_i = 1'b1;
            s_data_i  = 8'hEE;
            cycle();
            total++;
            if (s_ready_o !== 1'b0) begin bad++; $display("FAIL full_hold_%0d: ready=%b expected 0", c, s_ready_o); end
        end
        total++;
        if (n_push - start != 19) begin bad++; $display("FAIL full_extra: got %0d expected 19", n_push - start); end
        s_valid_i = 1'b0;
        m_ready_i = 1'b1;
        repeat (25) cycle();
        total++;
        if (empty_o !== 1'b1) begin bad++; $display("FAIL full_drain: got %b expected 1", empty_o); end
    endtask

    task automatic test_random();
        int start;
        int cyc;
        start = n_push;
        cyc = 0;
        while ((n_push - start < 100 || sb_q.size() != 0) && cyc < 3000) begin
            s_valid_i = (n_push - start < 100) && ($urandom_range(0, 3) != 0);
            s_data_i  = DATA_W'($urandom);
            m_ready_i = ($urandom_range(0, 1) != 0);
            cycle();
            cyc++;
        end
        s_valid_i = 1'b0;
        total++;
        if (n_push - start != 100 || sb_q.size() != 0)
            begin bad++; $display("FAIL random_done: pushed %0d left %0d expected 100 and 0", n_push - start, sb_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_ready_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = DATA_W'(8'h10 + i);
            cycle();
        end
        s_valid_i = 1'b0;
        cycle();
        m_ready_i = 1'b1;
        cycle();
        m_ready_i = 1'b0;
        total++;
        if (count_o !== CNT_W'(6)) begin bad++; $display("FAIL mid_count: got %0d expected 6", count_o); end
        // A read issues in this cycle; reset lands on the same edge.
        do_reset();
        total += 3;
        if (count_o !== '0)     begin bad++; $display("FAIL mid_rst_count: got %0d expected 0", count_o); end
        if (m_valid_o !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b expected 0", m_valid_o); end
        if (s_ready_o !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %b expected 1", s_ready_o); end
        check_latency(8'h3C, "mid_first");
    endtask

    task automatic test_stream();
        do_reset();
        s_valid_i = 1'b1;
        m_ready_i = 1'b1;
        for (int k = 0; k < 50; k++) begin
            s_data_i = DATA_W'(8'h80 + k);
            if (k >= 3) begin
                total += 2;
                if (m_valid_o !== 1'b1)    begin bad++; $display("FAIL stream_valid_%0d: got %b expected 1", k, m_valid_o); end
                if (count_o !== CNT_W'(3)) begin bad++; $display("FAIL stream_count_%0d: got %0d expected 3", k, count_o); end
            end
            total++;
            if (s_ready_o !== 1'b1) begin bad++; $display("FAIL stream_ready_%0d: got %b expected 1", k, s_ready_o); end
            cycle();
        end
        s_valid_i = 1'b0;
        repeat (6) cycle();
        total++;
        if (empty_o !== 1'b1) begin bad++; $display("FAIL stream_drain: got %b expected 1", empty_o); end
    endtask

    initial begin
        rstn_i    = 1'b0;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        m_ready_i = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_latency();
        test_stall_burst();
        test_full();
        test_random();
        test_reset_mid();
        test_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
